// File: rtl/kyber_enc_seq.sv
// rtl/kyber_enc_seq.sv - streaming sequencer around kyber_enc_core; optional build macro KYBER_SEQ_UNMASK_EN
module kyber_enc_seq #(
    parameter int IN_WORDS   = 224,
    parameter int OUT_WORDS  = 192,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data0,
    output logic [31:0] m_data1,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        core_en,
    output logic        core_wen,
    output logic [31:0] core_din,
    input  logic [31:0] core_dout0,
    input  logic [31:0] core_dout1,
    input  logic        core_valid
);
    localparam int IN_CW  = $clog2(IN_WORDS) + 1;
    localparam int OUT_CW = $clog2(OUT_WORDS) + 1;
    localparam int TO_CW  = $clog2(TIMEOUT) + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
`ifdef KYBER_SEQ_UNMASK_EN
    localparam int FW = 32;
`else
    localparam int FW = 64;
`endif

    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(IN_WORDS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUT_WORDS - 1);
    localparam logic [TO_CW-1:0]  TO_LAST  = TO_CW'(TIMEOUT - 1);
    localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_GAP, S_LOAD, S_DRAIN, S_FLUSH, S_DONE, S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IN_CW-1:0]  in_cnt;
    logic [OUT_CW-1:0] out_cnt;
    logic [TO_CW-1:0]  idle_cnt;

    logic [FW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;

    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_vis;
    logic              push;
    logic              pop;
    logic              overflow;
    logic              push_ok;
    logic [FW-1:0]     push_word;
    logic [FW-1:0]     head_word;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    // The host only sees FIFO contents while a result is being produced.
    assign fifo_vis   = ((state == S_DRAIN) || (state == S_FLUSH)) && !fifo_empty;
    assign pop        = fifo_vis && m_ready;
    assign push       = (state == S_DRAIN) && core_valid;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign overflow   = push && fifo_full && !pop;
    assign push_ok    = push && !overflow;
    assign head_word  = mem[rd_ptr];

    // Shares stay separate unless the unmasked build explicitly combines them.
    always_comb begin
`ifdef KYBER_SEQ_UNMASK_EN
        push_word = core_dout0 ^ core_dout1;
`else
        push_word = {core_dout1, core_dout0};
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_START;
            S_START: state_nxt = S_GAP;
            S_GAP:   state_nxt = S_LOAD;
            S_LOAD:  if (s_valid && (in_cnt == IN_LAST)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (overflow) begin
                    state_nxt = S_ERR;
                end else if (push && (out_cnt == OUT_LAST)) begin
                    state_nxt = S_FLUSH;
                end else if (!core_valid && (idle_cnt == TO_LAST)) begin
                    state_nxt = S_ERR;
                end
            end
            // Leave as soon as the last word pops so done follows it directly.
            S_FLUSH: if (fifo_empty || (pop && (fifo_cnt == CNT_ONE))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; data outputs are forced to zero whenever they are not valid.
    always_comb begin
        core_en  = (state == S_START);
        s_ready  = (state == S_LOAD);
        core_wen = (state == S_LOAD) && s_valid;
        core_din = (state == S_LOAD) ? s_data : 32'd0;
        busy     = (state == S_START) || (state == S_GAP) || (state == S_LOAD) ||
                   (state == S_DRAIN) || (state == S_FLUSH);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        m_valid  = fifo_vis;
        m_data0  = 32'd0;
        m_data1  = 32'd0;
        if (fifo_vis) begin
`ifdef KYBER_SEQ_UNMASK_EN
            m_data0 = head_word;
`else
            m_data0 = head_word[31:0];
            m_data1 = head_word[63:32];
`endif
        end
    end

    // Input, output and idle counters; they stop rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == S_IDLE) begin
                in_cnt <= '0;
            end else if ((state == S_LOAD) && s_valid) begin
                in_cnt <= in_cnt + IN_CW'(1);
            end

            if (state == S_IDLE) begin
                out_cnt <= '0;
            end else if (push_ok) begin
                out_cnt <= out_cnt + OUT_CW'(1);
            end

            if ((state != S_DRAIN) || core_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_CW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; an error discards whatever was queued.
    always_ff @(posedge clk) begin
        if (rst || (state == S_ERR)) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_ONE;
            end else if (!push_ok && pop) begin
                fifo_cnt <= fifo_cnt - CNT_ONE;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

endmodule

// File: tb/tb_kyber_enc_seq.sv
// tb/tb_kyber_enc_seq.sv - self-checking bench for kyber_enc_seq
module tb_kyber_enc_seq;
    localparam int IN_W  = 224;
    localparam int OUT_W = 192;
    localparam int DEPTH = 16;
    localparam int TMO   = 64;
    localparam int M_NOM = 0;
    localparam int M_BUB = 1;
    localparam int M_BKP = 2;
    localparam int M_TMO = 3;
    localparam int M_RST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data0;
    logic [31:0] m_data1;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_en;
    logic        core_wen;
    logic [31:0] core_din;
    logic [31:0] core_dout0;
    logic [31:0] core_dout1;
    logic        core_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] in_words [IN_W];
    logic [31:0] golden   [OUT_W];
    logic [31:0] share0   [OUT_W];
    logic [31:0] share1   [OUT_W];
    logic [63:0] exp_q [$];

    int   wen_cnt, din_bad, in_idx, core_idx, occ, pops;
    int   done_cnt, done_cyc, last_pop_cyc, drain_cyc, last_valid_cyc, ovf_cyc;
    logic finished;

    kyber_enc_seq #(
        .IN_WORDS(IN_W), .OUT_WORDS(OUT_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data0(m_data0), .m_data1(m_data1), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err),
        .core_en(core_en), .core_wen(core_wen), .core_din(core_din),
        .core_dout0(core_dout0), .core_dout1(core_dout1), .core_valid(core_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({s_ready, m_valid, busy, done, err, core_en, core_wen}), 64'd0);
        chk({tag, "_mdata"}, {m_data1, m_data0}, 64'd0);
        chk({tag, "_din"}, 64'(core_din), 64'd0);
    endtask

    // Golden ciphertext is an arbitrary function of the inputs; shares mask it with a random word.
    task automatic gen_vectors();
        exp_q.delete();
        for (int i = 0; i < IN_W; i++) in_words[i] = $urandom;
        for (int i = 0; i < OUT_W; i++) begin
            golden[i] = in_words[(i * 7) % IN_W] ^ (32'(i) * 32'h0100_0193) ^ in_words[(i + IN_W - 1) % IN_W];
            share0[i] = $urandom;
            share1[i] = golden[i] ^ share0[i];
`ifdef KYBER_SEQ_UNMASK_EN
            exp_q.push_back({32'd0, golden[i]});
`else
            exp_q.push_back({share1[i], share0[i]});
`endif
        end
    endtask

    task automatic run_enc(input int mode);
        logic emit;
        wen_cnt = 0; din_bad = 0; in_idx = 0; core_idx = 0; occ = 0; pops = 0;
        done_cnt = 0; done_cyc = -10; last_pop_cyc = -10; drain_cyc = -1;
        last_valid_cyc = -1; ovf_cyc = -1; finished = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; s_valid = 1'b0; core_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #3;
        chk("core_en_pulse", 64'({core_en, busy, s_ready}), 64'b110);
        @(posedge clk); #4;
        chk("gap_cycle", 64'({core_en, busy, s_ready}), 64'b010);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            s_valid = (mode == M_BUB) ? ((cyc % 2) == 1) : 1'b1;
            s_data  = (in_idx < IN_W) ? in_words[in_idx] : $urandom;
            core_valid = 1'b0;
            core_dout0 = $urandom;
            core_dout1 = $urandom;
            if (drain_cyc >= 0 && cyc >= drain_cyc + 1 && core_idx < OUT_W) begin
                emit = 1'b1;
                if (mode == M_TMO && core_idx >= 10) emit = 1'b0;
                if (mode == M_BUB && ((($urandom % 2) == 0) || occ >= 12)) emit = 1'b0;
                if (emit) begin
                    core_valid = 1'b1;
                    core_dout0 = share0[core_idx];
                    core_dout1 = share1[core_idx];
                end
            end
            case (mode)
                M_BUB:   m_ready = (($urandom % 4) != 0);
                M_BKP:   m_ready = (drain_cyc < 0) || (cyc >= drain_cyc + 20);
                default: m_ready = 1'b1;
            endcase
            #3;
            if (cyc == 0) chk("s_ready_t3", 64'(s_ready), 64'd1);
            if (core_wen) begin
                wen_cnt++;
                if (core_din !== s_data) din_bad++;
            end
            if (core_wen !== (s_valid && s_ready)) din_bad++;
            if (s_valid && s_ready) begin
                in_idx++;
                if (in_idx == IN_W) drain_cyc = cyc + 1;
            end
            if (core_valid) begin
                core_idx++;
                occ++;
                last_valid_cyc = cyc;
                if (mode == M_BKP && core_idx == DEPTH + 1) ovf_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                pops++;
                occ--;
                last_pop_cyc = cyc;
                if (exp_q.size() > 0) chk("m_word", {m_data1, m_data0}, exp_q.pop_front());
                else chk("m_extra_pop", 64'(pops), 64'(OUT_W));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            if (mode == M_RST && in_idx == 100) begin
                finished = 1'b1;
                break;
            end
            if (mode == M_BKP && ovf_cyc >= 0 && cyc == ovf_cyc) chk("err_at_17th_push", 64'(err), 64'd0);
            if (mode == M_BKP && ovf_cyc >= 0 && cyc == ovf_cyc + 1) begin
                chk("ovf_state", 64'({err, busy, m_valid, s_ready}), 64'b1000);
                finished = 1'b1;
                break;
            end
            if (mode == M_TMO && core_idx == 10) begin
                if (cyc == last_valid_cyc + TMO) chk("err_before_timeout", 64'(err), 64'd0);
                if (cyc == last_valid_cyc + TMO + 1) begin
                    chk("timeout_state", 64'({err, busy, m_valid}), 64'b100);
                    finished = 1'b1;
                    break;
                end
            end
            if ((mode == M_NOM || mode == M_BUB) && done_cnt > 0 && cyc == done_cyc + 1) begin
                finished = 1'b1;
                break;
            end
        end
        chk("run_finished", 64'(finished), 64'd1);
    endtask

    task automatic check_complete(input string tag);
        chk({tag, "_wen_cnt"}, 64'(wen_cnt), 64'(IN_W));
        chk({tag, "_din_bad"}, 64'(din_bad), 64'd0);
        chk({tag, "_pops"}, 64'(pops), 64'(OUT_W));
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_pop_cyc + 1));
        chk({tag, "_q_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_err_busy"}, 64'({err, busy}), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b1; s_data = $urandom; core_valid = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        check_all_zero(tag);
        s_valid = 1'b0; core_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
        core_valid = 1'b0; core_dout0 = 32'd0; core_dout1 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3 check_all_zero("reset");

        gen_vectors();
        run_enc(M_NOM);
        check_complete("nominal");

        gen_vectors();
        run_enc(M_BUB);
        check_complete("bubbled");

        gen_vectors();
        run_enc(M_RST);
        chk("rst_mid_in_idx", 64'(in_idx), 64'd100);
        pulse_reset("rst_mid");
        gen_vectors();
        run_enc(M_NOM);
        check_complete("after_rst");

        gen_vectors();
        run_enc(M_BKP);
        chk("bkp_pops", 64'(pops), 64'd0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #3;
        chk("err_ignores_start", 64'({err, busy, core_en, m_valid}), 64'b1000);
        pulse_reset("rst_after_ovf");

        gen_vectors();
        run_enc(M_TMO);
        chk("tmo_done_cnt", 64'(done_cnt), 64'd0);
        chk("tmo_pops", 64'(pops), 64'd10);
        pulse_reset("rst_after_tmo");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
